wshb_mire: RTL and testbench

//  Wishbone master that continuously writes a grid test pattern ("mire") into the

---
 rtl/video_pkg.sv | 24 ++
 rtl/mire_xy_counter.sv | 47 ++++
 rtl/wshb_mire.sv | 115 +++++++++++
 tb/tb_wshb_mire.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants, pixel colours and the mire write FSM state type.
// Also holds the grid colour rule used by the pattern generator.
package video_pkg;

   localparam int unsigned DEFAULT_HDISP = 800;
   localparam int unsigned DEFAULT_VDISP = 480;

   localparam logic [31:0] WHITE = 32'h00FF_FFFF;
   localparam logic [31:0] BLACK = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RELEASE
   } mireState_t;

   // A pixel is white when it sits on a vertical or a horizontal grid line.
   function automatic logic [31:0] gridColour(input int unsigned px,
                                              input int unsigned py,
                                              input int unsigned grid);
      return ((px % grid) == 0 || (py % grid) == 0) ? WHITE : BLACK;
   endfunction

endpackage

// File: rtl/mire_xy_counter.sv
// Raster walk over the visible frame: x/y position plus the matching byte address.
// The address steps by 4 per pixel and wraps to 0 together with x and y.
module mire_xy_counter #(
   parameter int unsigned HDISP = 800,
   parameter int unsigned VDISP = 480
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inc,
   output logic [$clog2(HDISP)-1:0]   x,
   output logic [$clog2(VDISP)-1:0]   y,
   output logic [31:0]                adr,
   output logic                       last
);

   localparam int XW = $clog2(HDISP);
   localparam int YW = $clog2(VDISP);

   logic lineEnd;

   assign lineEnd = (x == XW'(HDISP - 1));
   assign last    = lineEnd && (y == YW'(VDISP - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         x   <= '0;
         y   <= '0;
         adr <= '0;
      end else if (inc) begin
         if (last) begin
            x   <= '0;
            y   <= '0;
            adr <= '0;
         end else if (lineEnd) begin
            x   <= '0;
            y   <= y + 1'b1;
            adr <= adr + 32'd4;
         end else begin
            x   <= x + 1'b1;
            adr <= adr + 32'd4;
         end
      end
   end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone write master that streams a white grid test pattern into the frame buffer,
// in bursts of BURST_LEN acked writes with cyc released for GAP cycles in between.
module wshb_mire
   import video_pkg::*;
#(
   parameter int unsigned HDISP     = DEFAULT_HDISP,
   parameter int unsigned VDISP     = DEFAULT_VDISP,
   parameter int unsigned GRID      = 16,
   parameter int unsigned BURST_LEN = 64,
   parameter int unsigned GAP       = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        cyc,
   output logic        stb,
   output logic        we,
   output logic [31:0] adr,
   output logic [31:0] dat_ms,
   output logic [3:0]  sel,
   output logic [2:0]  cti,
   output logic [1:0]  bte,
   input  logic        ack,
   input  logic [31:0] dat_sm
);

   localparam int XW = $clog2(HDISP);
   localparam int YW = $clog2(VDISP);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int GW = $clog2(GAP + 1);

   mireState_t      state, nextState;
   logic            idleDone;
   logic [BW-1:0]   burstCnt;
   logic [GW-1:0]   gapCnt;
   logic            inc;
   logic            last;
   logic            tenureEnd;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            unusedDatSm;

   assign we  = 1'b1;
   assign sel = 4'hF;
   assign cti = 3'b000;
   assign bte = 2'b00;
   assign unusedDatSm = ^dat_sm;

   assign tenureEnd = (burstCnt == BW'(BURST_LEN - 1)) || last;

   mire_xy_counter #(
      .HDISP (HDISP),
      .VDISP (VDISP)
   ) u_xy (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .x    (x),
      .y    (y),
      .adr  (adr),
      .last (last)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      nextState = state;
      cyc       = 1'b0;
      stb       = 1'b0;
      inc       = 1'b0;
      case (state)
         IDLE: begin
            if (idleDone) nextState = WRITE;
         end
         WRITE: begin
            cyc = 1'b1;
            stb = 1'b1;
            if (ack) begin
               inc = 1'b1;
               if (tenureEnd) nextState = RELEASE;
            end
         end
         RELEASE: begin
            if (gapCnt == '0) nextState = WRITE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Pixel data is loaded with the next address so the pair is always coherent.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idleDone <= 1'b0;
         burstCnt <= '0;
         gapCnt   <= '0;
         dat_ms   <= BLACK;
      end else begin
         state    <= nextState;
         idleDone <= 1'b1;

         if (inc) burstCnt <= tenureEnd ? '0 : burstCnt + 1'b1;

         if (state == WRITE && nextState == RELEASE)
            gapCnt <= GW'(GAP - 1);
         else if (state == RELEASE && gapCnt != '0)
            gapCnt <= gapCnt - 1'b1;

         if (state == IDLE)
            dat_ms <= gridColour(32'(x), 32'(y), GRID);
         else if (inc)
            dat_ms <= (x == XW'(HDISP - 1)) ? WHITE
                                            : gridColour(32'(x) + 32'd1, 32'(y), GRID);
      end
   end

endmodule

// File: tb/tb_wshb_mire.sv
// Randomised-ack bench for wshb_mire: a full-size instance and an 8x4 instance,
// both checked every cycle against a pixel-index reference model.
module tb_wshb_mire;

   localparam int BURST = 64;
   localparam int GAP   = 1;
   localparam int GRID  = 16;

   logic        clk;
   logic        rst;
   logic        ackA, ackB;
   logic        cycA, stbA, weA, cycB, stbB, weB;
   logic [31:0] adrA, datA, adrB, datB;
   logic [3:0]  selA, selB;
   logic [2:0]  ctiA, ctiB;
   logic [1:0]  bteA, bteB;
   logic [31:0] datSm;

   int checkCnt = 0;
   int passCnt  = 0;

   int pix[2];
   int burst[2];
   int lowLeft[2];
   bit live[2];

   assign datSm = 32'h0;

   wshb_mire dutA (
      .clk(clk), .rst(rst), .cyc(cycA), .stb(stbA), .we(weA), .adr(adrA),
      .dat_ms(datA), .sel(selA), .cti(ctiA), .bte(bteA), .ack(ackA), .dat_sm(datSm)
   );

   wshb_mire #(.HDISP(8), .VDISP(4)) dutB (
      .clk(clk), .rst(rst), .cyc(cycB), .stb(stbB), .we(weB), .adr(adrB),
      .dat_ms(datB), .sel(selB), .cti(ctiB), .bte(bteB), .ack(ackB), .dat_sm(datSm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] expPixel(input int n, input int hd);
      int px = n % hd;
      int py = n / hd;
      return (px % GRID == 0 || py % GRID == 0) ? 32'h00FF_FFFF : 32'h0;
   endfunction

   // Called at the falling edge: whatever is on the bus now is what the next rising edge sees.
   task automatic modelStep(input int d, input int hd, input int vd,
                            input logic c, input logic s, input logic a,
                            input logic [31:0] ad, input logic [31:0] dt);
      string pre = (d == 0) ? "A" : "B";
      bit wrapped;
      if (rst) begin
         live[d]    = 1'b1;
         pix[d]     = 0;
         burst[d]   = 0;
         lowLeft[d] = 2;
      end else if (live[d]) begin
         if (lowLeft[d] > 0) begin
            check({pre, ".cycLow"}, 32'(c), 32'd0);
            lowLeft[d]--;
         end else begin
            check({pre, ".cyc"}, 32'(c), 32'd1);
            check({pre, ".stb"}, 32'(s), 32'd1);
            check({pre, ".adr"}, ad, 32'(4 * pix[d]));
            check({pre, ".dat"}, dt, expPixel(pix[d], hd));
            if (a) begin
               wrapped  = (pix[d] == hd * vd - 1);
               pix[d]   = (pix[d] + 1) % (hd * vd);
               burst[d] = burst[d] + 1;
               if (burst[d] == BURST || wrapped) begin
                  burst[d]   = 0;
                  lowLeft[d] = GAP;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      modelStep(0, 800, 480, cycA, stbA, ackA, adrA, datA);
      modelStep(1, 8, 4, cycB, stbB, ackB, adrB, datB);
   end

   initial begin
      ackB = 1'b0;
      forever begin
         @(posedge clk);
         #1 ackB = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      int waited;
      rst  = 1'b1;
      ackA = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.cyc", 32'(cycA), 32'd0);
      check("rst.stb", 32'(stbA), 32'd0);
      check("rst.adr", adrA, 32'd0);
      check("rst.dat", datA, 32'd0);
      check("const.we", 32'(weA), 32'd1);
      check("const.sel", 32'(selA), 32'hF);
      check("const.cti", 32'(ctiA), 32'd0);
      check("const.bte", 32'(bteA), 32'd0);

      // Continuous ack: first bursts and the y=16 grid line.
      @(posedge clk);
      #1 rst = 1'b0;
      ackA = 1'b1;
      repeat (14000) @(posedge clk);

      // Five-cycle stalls before each ack.
      repeat (20) begin
         #1 ackA = 1'b0;
         repeat (5) @(posedge clk);
         #1 ackA = 1'b1;
         @(posedge clk);
      end

      repeat (3000) begin
         @(posedge clk);
         #1 ackA = ($urandom_range(0, 3) != 0);
      end

      // Reset mid-burst with ack asserted on the reset edge.
      waited = 0;
      while (!cycA && waited < 100) begin
         @(posedge clk);
         #1 waited++;
      end
      check("midBurst.cyc", 32'(cycA), 32'd1);
      rst  = 1'b1;
      ackA = 1'b1;
      @(posedge clk);
      #1;
      check("rstAck.cyc", 32'(cycA), 32'd0);
      check("rstAck.adr", adrA, 32'd0);
      rst = 1'b0;
      repeat (600) @(posedge clk);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
